sobel_window_generator_module: RTL and testbench
================================================

# sobel_window_generator_module

Producer side of the 3x3 window bus consumed by the Sobel edge-detect filters. Accepts a raster-order stream of 12-bit RGB444 pixels, buffers two previous image rows, and emits one packed 108-bit 3x3 neighbourhood per interior pixel. It sits between the camera/frame-source stream and the Sobel X/Y filter modules.

## Interface
- IMG_WIDTH, 640, pixels per row (≥3)
- IMG_HEIGHT, 480, rows per frame (≥3)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- pix_in  input  12  RGB444 pixel, [11:8] R, [7:4] G, [3:0] B
- pix_valid  input  1  pix_in valid this cycle; stalls allowed
- sof  input  1  qualifies the first pixel of a frame; sampled only with pix_valid
- color_data  output  108  packed window: [107:96] centre, [95:84] left, [83:72] right, [71:60] up, [59:48] down, [47:36] up-left, [35:24] up-right, [23:12] down-left, [11:0] down-right
- window_valid  output  1  color_data holds a new window, one-cycle pulse
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted

## Operation
- Accepted pixel = pix_valid high on a clk edge; other cycles change no state.
- States: IDLE, RUN. IDLE ignores pixels until pix_valid&&sof; that pixel becomes (x=0,y=0) and the state moves to RUN.
- RUN: column counter x wraps IMG_WIDTH-1→0 and increments y; the accepted pixel at (IMG_WIDTH-1, IMG_HEIGHT-1) returns to IDLE and pulses frame_done.
- pix_valid&&sof in RUN: restart; that pixel is (0,0); no window is emitted for it; line-buffer contents are treated as stale.
- Two line buffers: LB1 holds row y-1, LB2 holds row y-2. On each accept at column x: read LB1[x], LB2[x]; write LB2[x]←old LB1[x], LB1[x]←pix_in.
- A 3-column shift register (top/mid/bottom rows) shifts left on each accept and loads {LB2[x], LB1[x], pix_in}; it is cleared when x=0.
- Window emitted when the accepted pixel has x≥2 and y≥2; centre is (x-1, y-1). Output count per frame is (IMG_WIDTH-2)*(IMG_HEIGHT-2). Border pixels produce no window.
- No arithmetic; pixel values pass through bit-exact.

## Timing
- Reset: state IDLE; x, y, shift registers, color_data, window_valid, frame_done all 0. Line-buffer contents are not reset and are never read before being written within the frame.
- Latency: window_valid and color_data update on the clk edge after the accepting edge (1 cycle). color_data holds its value until the next window.
- Throughput: one pixel per clock; back-to-back windows when pix_valid is continuous.
- frame_done asserts on the same edge as the final window_valid.
- Reset asserted mid-frame: immediate return to reset state; the next frame needs sof.

## Configuration
- WINDOW_POS_OUT_EN defined: adds outputs center_x [$clog2(IMG_WIDTH)-1:0] and center_y [$clog2(IMG_HEIGHT)-1:0], registered alongside color_data and giving the centre coordinates (reset 0).
- Without the macro: these ports and their registers are absent; all other behaviour is identical.

## Structure
- Shared package sobel_window_pkg: PIXEL_W=12, WINDOW_W=108, slot LSB constants (CENTER=96, LEFT=84, RIGHT=72, UP=60, DOWN=48, UPLEFT=36, UPRIGHT=24, DOWNLEFT=12, DOWNRIGHT=0), and the state enum. The Sobel X/Y filters share these constants.
- Sub-module line_buffer: IMG_WIDTH×12 memory with one address per cycle and read-old-during-write. Instantiated twice.

## Test plan
- IMG_WIDTH=IMG_HEIGHT=4, pixel=12'h0YX (for example (2,1)→12'h012), continuous stream with sof on the first pixel. Expect 4 windows. The first has centre 011, left 010, right 012, up 001, down 021, up-left 000, up-right 002, down-left 020, down-right 022. frame_done coincides with the 4th window (centre 022).
- Same frame with pix_valid toggled at random. Expect identical windows and order, with no window while pix_valid is low.
- Pixels without sof while in IDLE. Expect no windows and no frame_done.
- sof reasserted at (2,2) of a frame, then a full new frame. Expect no window from the aborted frame after the restart, then 4 correct windows.
- reset asserted low mid-row. Expect all outputs 0 immediately; the next sof frame is correct.
- With WINDOW_POS_OUT_EN: 4×4 frame. Expect center_x/center_y = (1,1),(2,1),(1,2),(2,2).

Source files
------------

// File: rtl/sobel_window_pkg.sv
// rtl/sobel_window_pkg.sv - shared pixel/window widths, window slot offsets and state encoding
package sobel_window_pkg;

    localparam int PIXEL_W  = 12;
    localparam int WINDOW_W = 9 * PIXEL_W;

    // LSB of each neighbour slot inside the packed 3x3 window
    localparam int CENTER    = 96;
    localparam int LEFT      = 84;
    localparam int RIGHT     = 72;
    localparam int UP        = 60;
    localparam int DOWN      = 48;
    localparam int UPLEFT    = 36;
    localparam int UPRIGHT   = 24;
    localparam int DOWNLEFT  = 12;
    localparam int DOWNRIGHT = 0;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    function automatic logic [WINDOW_W-1:0] pack_window(
        input logic [PIXEL_W-1:0] c,
        input logic [PIXEL_W-1:0] l,
        input logic [PIXEL_W-1:0] r,
        input logic [PIXEL_W-1:0] u,
        input logic [PIXEL_W-1:0] d,
        input logic [PIXEL_W-1:0] ul,
        input logic [PIXEL_W-1:0] ur,
        input logic [PIXEL_W-1:0] dl,
        input logic [PIXEL_W-1:0] dr
    );
        logic [WINDOW_W-1:0] w;
        w = '0;
        w[CENTER    +: PIXEL_W] = c;
        w[LEFT      +: PIXEL_W] = l;
        w[RIGHT     +: PIXEL_W] = r;
        w[UP        +: PIXEL_W] = u;
        w[DOWN      +: PIXEL_W] = d;
        w[UPLEFT    +: PIXEL_W] = ul;
        w[UPRIGHT   +: PIXEL_W] = ur;
        w[DOWNLEFT  +: PIXEL_W] = dl;
        w[DOWNRIGHT +: PIXEL_W] = dr;
        return w;
    endfunction

endpackage

// File: rtl/sobel_window_generator_module_if.sv
// rtl/sobel_window_generator_module_if.sv - pixel-in / window-out bus; WINDOW_POS_OUT_EN adds centre coordinates
interface sobel_window_generator_module_if
`ifdef WINDOW_POS_OUT_EN
    #(
        parameter int IMG_WIDTH  = 640,
        parameter int IMG_HEIGHT = 480
    )
`endif
    ;
    import sobel_window_pkg::*;

    logic [PIXEL_W-1:0]  pix_in;
    logic                pix_valid;
    logic                sof;
    logic [WINDOW_W-1:0] color_data;
    logic                window_valid;
    logic                frame_done;

`ifdef WINDOW_POS_OUT_EN
    logic [$clog2(IMG_WIDTH)-1:0]  center_x;
    logic [$clog2(IMG_HEIGHT)-1:0] center_y;

    modport master (
        output pix_in, pix_valid, sof,
        input  color_data, window_valid, frame_done, center_x, center_y
    );

    modport slave (
        input  pix_in, pix_valid, sof,
        output color_data, window_valid, frame_done, center_x, center_y
    );
`else
    modport master (
        output pix_in, pix_valid, sof,
        input  color_data, window_valid, frame_done
    );

    modport slave (
        input  pix_in, pix_valid, sof,
        output color_data, window_valid, frame_done
    );
`endif

endinterface

// File: rtl/sobel_window_generator_module_line_buffer.sv
// rtl/sobel_window_generator_module_line_buffer.sv - one image row of pixels, single address, read-old-during-write
module line_buffer
    import sobel_window_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int WIDTH = PIXEL_W
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic                     we,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    // Write lands on the edge, so the combinational read still sees the previous row's value
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sobel_window_generator_module.sv
// rtl/sobel_window_generator_module.sv - raster pixel stream to 3x3 window generator; WINDOW_POS_OUT_EN adds centre coordinates
module sobel_window_generator_module
    import sobel_window_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                           clk,
    input  logic                           reset,
    sobel_window_generator_module_if.slave win
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);

    localparam logic [0:0] IDLE = S_IDLE;
    localparam logic [0:0] RUN  = S_RUN;

    logic [0:0]          state;
    logic [XW-1:0]       x;
    logic [YW-1:0]       y;
    logic                start, step, write, row_start;
    logic                last_col, last_row, emit, done;
    logic [XW-1:0]       col_x;
    logic [PIXEL_W-1:0]  lb1_q, lb2_q;
    logic [PIXEL_W-1:0]  top_sr [3];
    logic [PIXEL_W-1:0]  mid_sr [3];
    logic [PIXEL_W-1:0]  bot_sr [3];
    logic                emit_q, done_q;
    logic [WINDOW_W-1:0] color_data;
    logic                window_valid, frame_done;

    // sof restarts from any state; ordinary pixels only count while a frame is running
    assign start     = win.pix_valid && win.sof;
    assign step      = win.pix_valid && !win.sof && (state == RUN);
    assign write     = start || step;
    assign col_x     = start ? '0 : x;
    assign row_start = (col_x == '0);
    assign last_col  = (x == XW'(IMG_WIDTH - 1));
    assign last_row  = (y == YW'(IMG_HEIGHT - 1));
    assign emit      = step && (x >= XW'(2)) && (y >= YW'(2));
    assign done      = step && last_col && last_row;

    line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
        .clk   (clk),
        .addr  (col_x),
        .we    (write),
        .wdata (win.pix_in),
        .rdata (lb1_q)
    );

    line_buffer #(.DEPTH(IMG_WIDTH)) u_lb2 (
        .clk   (clk),
        .addr  (col_x),
        .we    (write),
        .wdata (lb1_q),
        .rdata (lb2_q)
    );

    // Frame state and raster position of the next pixel to be accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
        end else if (start) begin
            state <= RUN;
            x     <= XW'(1);
            y     <= '0;
        end else if (step) begin
            if (last_col) begin
                x <= '0;
                if (last_row) begin
                    state <= IDLE;
                    y     <= '0;
                end else begin
                    y <= y + YW'(1);
                end
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    // Three-column window history; older columns are dropped at the start of each row
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                top_sr[i] <= '0;
                mid_sr[i] <= '0;
                bot_sr[i] <= '0;
            end
        end else if (write) begin
            top_sr[0] <= row_start ? '0 : top_sr[1];
            mid_sr[0] <= row_start ? '0 : mid_sr[1];
            bot_sr[0] <= row_start ? '0 : bot_sr[1];
            top_sr[1] <= row_start ? '0 : top_sr[2];
            mid_sr[1] <= row_start ? '0 : mid_sr[2];
            bot_sr[1] <= row_start ? '0 : bot_sr[2];
            top_sr[2] <= lb2_q;
            mid_sr[2] <= lb1_q;
            bot_sr[2] <= win.pix_in;
        end
    end

    // Window and frame-end flags trail the shift register by one edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            emit_q       <= 1'b0;
            done_q       <= 1'b0;
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
            color_data   <= '0;
        end else begin
            emit_q       <= emit;
            done_q       <= done;
            window_valid <= emit_q;
            frame_done   <= done_q;
            if (emit_q) begin
                color_data <= pack_window(mid_sr[1], mid_sr[0], mid_sr[2],
                                          top_sr[1], bot_sr[1],
                                          top_sr[0], top_sr[2],
                                          bot_sr[0], bot_sr[2]);
            end
        end
    end

    assign win.color_data   = color_data;
    assign win.window_valid = window_valid;
    assign win.frame_done   = frame_done;

`ifdef WINDOW_POS_OUT_EN
    logic [XW-1:0] cx_q, center_x;
    logic [YW-1:0] cy_q, center_y;

    // Centre is one column left and one row up from the pixel that completed the window
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cx_q     <= '0;
            cy_q     <= '0;
            center_x <= '0;
            center_y <= '0;
        end else begin
            if (emit) begin
                cx_q <= x - XW'(1);
                cy_q <= y - YW'(1);
            end
            if (emit_q) begin
                center_x <= cx_q;
                center_y <= cy_q;
            end
        end
    end

    assign win.center_x = center_x;
    assign win.center_y = center_y;
`endif

endmodule

// File: tb/tb_sobel_window_generator_module.sv
// tb/tb_sobel_window_generator_module.sv - directed bench with image-array reference model for the window generator
module tb_sobel_window_generator_module;
    import sobel_window_pkg::*;

    localparam int W = 4;
    localparam int H = 4;

    localparam logic [107:0] FIRST_WIN = {12'h011, 12'h010, 12'h012, 12'h001, 12'h021,
                                          12'h000, 12'h002, 12'h020, 12'h022};

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

`ifdef WINDOW_POS_OUT_EN
    sobel_window_generator_module_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();
`else
    sobel_window_generator_module_if bus ();
`endif

    sobel_window_generator_module #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk   (clk),
        .reset (reset),
        .win   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [107:0] act, input logic [107:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: the frame as a 2-D image, windows read straight from it
    logic [11:0]  img [H][W];
    bit           m_run;
    int           m_x, m_y;
    bit           s1_valid, s1_done;
    logic [107:0] s1_win;
    int           s1_cx, s1_cy;
    bit           exp_valid, exp_done;
    logic [107:0] exp_color;
    int           exp_cx, exp_cy;

    logic [107:0] cap_win [$];
    bit           cap_done [$];
    int           cap_cx [$];
    int           cap_cy [$];
    int           done_count;
    logic [107:0] ref_win [$];

    function automatic logic [107:0] model_window(input int cx, input int cy);
        return {img[cy][cx], img[cy][cx-1], img[cy][cx+1], img[cy-1][cx], img[cy+1][cx],
                img[cy-1][cx-1], img[cy-1][cx+1], img[cy+1][cx-1], img[cy+1][cx+1]};
    endfunction

    task automatic model_clear();
        m_run = 0; m_x = 0; m_y = 0;
        s1_valid = 0; s1_done = 0; s1_win = '0; s1_cx = 0; s1_cy = 0;
        exp_valid = 0; exp_done = 0; exp_color = '0; exp_cx = 0; exp_cy = 0;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk);
            if (!reset) begin
                model_clear();
            end else begin
                exp_valid = s1_valid;
                exp_done  = s1_done;
                if (s1_valid) begin
                    exp_color = s1_win;
                    exp_cx    = s1_cx;
                    exp_cy    = s1_cy;
                end
                s1_valid = 0;
                s1_done  = 0;
                if (bus.pix_valid) begin
                    if (bus.sof) begin
                        img[0][0] = bus.pix_in;
                        m_run = 1; m_x = 1; m_y = 0;
                    end else if (m_run) begin
                        img[m_y][m_x] = bus.pix_in;
                        if (m_x >= 2 && m_y >= 2) begin
                            s1_valid = 1;
                            s1_cx    = m_x - 1;
                            s1_cy    = m_y - 1;
                            s1_win   = model_window(s1_cx, s1_cy);
                        end
                        if (m_x == W-1 && m_y == H-1) begin
                            s1_done = 1;
                            m_run   = 0;
                        end
                        if (m_x == W-1) begin
                            m_x = 0;
                            m_y = (m_y == H-1) ? 0 : m_y + 1;
                        end else begin
                            m_x++;
                        end
                    end
                end
            end
            @(negedge clk);
            if (!reset) model_clear();
            check("window_valid", bus.window_valid, exp_valid);
            check("frame_done", bus.frame_done, exp_done);
            check("color_data", bus.color_data, exp_color);
`ifdef WINDOW_POS_OUT_EN
            check("center_x", bus.center_x, exp_cx);
            check("center_y", bus.center_y, exp_cy);
`endif
            if (bus.window_valid) begin
                cap_win.push_back(bus.color_data);
                cap_done.push_back(bus.frame_done);
`ifdef WINDOW_POS_OUT_EN
                cap_cx.push_back(int'(bus.center_x));
                cap_cy.push_back(int'(bus.center_y));
`endif
            end
            if (bus.frame_done) done_count++;
        end
    end

    task automatic drive(input logic v, input logic s, input logic [11:0] p);
        bus.pix_valid = v;
        bus.sof       = s;
        bus.pix_in    = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b1, 12'($urandom));
    endtask

    function automatic logic [11:0] pixval(input int x, input int y);
        return 12'(y * 16 + x);
    endfunction

    task automatic clear_cap();
        cap_win.delete();
        cap_done.delete();
        cap_cx.delete();
        cap_cy.delete();
        done_count = 0;
    endtask

    task automatic send_frame(input bit gaps);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (gaps) idle($urandom_range(0, 2));
                drive(1'b1, (x == 0 && y == 0), pixval(x, y));
            end
        end
    endtask

    task automatic check_against_ref(input string tag);
        check({tag, "_count"}, 108'(cap_win.size()), 108'(4));
        check({tag, "_done_count"}, 108'(done_count), 108'(1));
        for (int i = 0; i < 4; i++) begin
            if (i < cap_win.size()) check({tag, "_window"}, cap_win[i], ref_win[i]);
        end
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.pix_in    = '0;
        done_count    = 0;
        reset         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_color_data", bus.color_data, 108'(0));
        check("reset_window_valid", bus.window_valid, 108'(0));
        check("reset_frame_done", bus.frame_done, 108'(0));
        reset = 1'b1;
        idle(2);

        // continuous frame
        clear_cap();
        send_frame(1'b0);
        idle(3);
        check("t1_count", 108'(cap_win.size()), 108'(4));
        check("t1_first_window", cap_win[0], FIRST_WIN);
        check("t1_second_centre", cap_win[1][107:96], 108'(12'h012));
        check("t1_third_centre", cap_win[2][107:96], 108'(12'h021));
        check("t1_last_centre", cap_win[3][107:96], 108'(12'h022));
        check("t1_done_with_last", cap_done[3], 108'(1));
        check("t1_done_count", 108'(done_count), 108'(1));
`ifdef WINDOW_POS_OUT_EN
        check("t1_cx0", 108'(cap_cx[0]), 108'(1)); check("t1_cy0", 108'(cap_cy[0]), 108'(1));
        check("t1_cx1", 108'(cap_cx[1]), 108'(2)); check("t1_cy1", 108'(cap_cy[1]), 108'(1));
        check("t1_cx2", 108'(cap_cx[2]), 108'(1)); check("t1_cy2", 108'(cap_cy[2]), 108'(2));
        check("t1_cx3", 108'(cap_cx[3]), 108'(2)); check("t1_cy3", 108'(cap_cy[3]), 108'(2));
`endif
        ref_win = '{FIRST_WIN,
                    {12'h012, 12'h011, 12'h013, 12'h002, 12'h022, 12'h001, 12'h003, 12'h021, 12'h023},
                    {12'h021, 12'h020, 12'h022, 12'h011, 12'h031, 12'h010, 12'h012, 12'h030, 12'h032},
                    {12'h022, 12'h021, 12'h023, 12'h012, 12'h032, 12'h011, 12'h013, 12'h031, 12'h033}};
        check_against_ref("t1");

        // stalled frame
        clear_cap();
        send_frame(1'b1);
        idle(3);
        check_against_ref("t2");

        // pixels without sof while idle
        clear_cap();
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, pixval(i % W, i / W));
        idle(3);
        check("t3_no_windows", 108'(cap_win.size()), 108'(0));
        check("t3_no_done", 108'(done_count), 108'(0));

        // restart at (2,2), then a complete frame
        clear_cap();
        for (int i = 0; i < 2 * W + 2; i++) drive(1'b1, (i == 0), pixval(i % W, i / W));
        drive(1'b1, 1'b1, pixval(0, 0));
        for (int i = 1; i < W * H; i++) drive(1'b1, 1'b0, pixval(i % W, i / W));
        idle(3);
        check_against_ref("t4");

        // reset mid-row
        clear_cap();
        for (int i = 0; i < 3 * W + 2; i++) drive(1'b1, (i == 0), pixval(i % W, i / W));
        bus.pix_valid = 1'b0;
        check("t5_pre_reset_windows", 108'(cap_win.size()), 108'(2));
        reset = 1'b0;
        #1;
        check("t5_reset_color_data", bus.color_data, 108'(0));
        check("t5_reset_window_valid", bus.window_valid, 108'(0));
        check("t5_reset_frame_done", bus.frame_done, 108'(0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        clear_cap();
        send_frame(1'b0);
        idle(3);
        check_against_ref("t5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
